// File: rtl/folded_hv_generator.sv
// Purpose: streams per-fold, per-modality, per-channel IM / ProjM slices for one latched feature sample.
// Latency: the first beat is valid the cycle after fin_fire; then one beat per cycle; one idle cycle between samples.
// Backpressure: dout_ready low holds every output stable; fin_ready is low for the whole sample.
module folded_hv_generator #(
   parameter int HV_DIMENSION      = 2000,
   parameter int FOLD_WIDTH        = 200,
   parameter int NUM_FOLDS         = 10,
   parameter int NUM_MODALITIES    = 3,
   parameter logic [8*NUM_MODALITIES-1:0] CHANNEL_COUNTS = {8'd105, 8'd77, 8'd32},
   parameter int TOTAL_NUM_CHANNEL = 214,
   parameter int CHANNEL_WIDTH     = 2,
   parameter logic [HV_DIMENSION-1:0] SEED_HV = {(HV_DIMENSION/8){8'hA5}},
   localparam int FOLD_BITS        = (NUM_FOLDS > 1) ? $clog2(NUM_FOLDS) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     fin_valid,
   output logic                     fin_ready,
   input  logic [CHANNEL_WIDTH-1:0] features [TOTAL_NUM_CHANNEL],
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [FOLD_WIDTH-1:0]    im_out,
   output logic [FOLD_WIDTH-1:0]    projm_out,
   output logic [FOLD_BITS-1:0]     dout_fold,
   output logic [3:0]               dout_modality,
   output logic                     dout_last_chan,
   output logic                     dout_last
);

   localparam int IDX_W = (TOTAL_NUM_CHANNEL > 1) ? $clog2(TOTAL_NUM_CHANNEL) : 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;

   // Channel count of modality m, taken from the packed table.
   function automatic logic [7:0] cnt_of(input int m);
      return CHANNEL_COUNTS[8*m +: 8];
   endfunction

   // Offset of modality m's first channel in the feature array.
   function automatic int base_of(input int m);
      int b;
      b = 0;
      for (int i = 0; i < m; i++) b += int'(cnt_of(i));
      return b;
   endfunction

   // Lowest-numbered modality that owns at least one channel.
   function automatic logic [3:0] first_nonempty();
      logic [3:0] f;
      f = 4'd0;
      for (int m = NUM_MODALITIES - 1; m >= 0; m--)
         if (cnt_of(m) != 8'd0) f = 4'(m);
      return f;
   endfunction

   // One Rule-90 step on a fold-wide slice, zero fill at both ends.
   function automatic logic [FOLD_WIDTH-1:0] r90(input logic [FOLD_WIDTH-1:0] x);
      return (x << 1) ^ (x >> 1);
   endfunction

   localparam int         COUNT_SUM = base_of(NUM_MODALITIES);
   localparam logic [3:0] FIRST_MOD = first_nonempty();
   localparam logic [HV_DIMENSION-1:0] PROJM_NEG = (SEED_HV << 1) ^ (SEED_HV >> 1);

   if (TOTAL_NUM_CHANNEL != COUNT_SUM) begin : g_bad_total
      $error("TOTAL_NUM_CHANNEL must equal the sum of CHANNEL_COUNTS");
   end
   if (COUNT_SUM == 0) begin : g_bad_empty
      $error("CHANNEL_COUNTS must contain at least one nonzero count");
   end
   if (NUM_MODALITIES < 1 || NUM_MODALITIES > 16) begin : g_bad_mods
      $error("NUM_MODALITIES must lie in 1..16");
   end
   if ((HV_DIMENSION % FOLD_WIDTH) != 0 || NUM_FOLDS != HV_DIMENSION / FOLD_WIDTH) begin : g_bad_fold
      $error("FOLD_WIDTH must divide HV_DIMENSION and NUM_FOLDS must equal the quotient");
   end

   logic [0:0]               state;
   logic [FOLD_BITS-1:0]     fold;
   logic [3:0]               modality;
   logic [7:0]               chan;
   logic [FOLD_WIDTH-1:0]    im;
   logic [CHANNEL_WIDTH-1:0] feat_mem [TOTAL_NUM_CHANNEL];

   logic [7:0]               cur_cnt;
   int                       cur_base;
   logic                     nxt_found;
   logic [3:0]               nxt_mod;
   logic [IDX_W-1:0]         feat_idx;
   logic [CHANNEL_WIDTH-1:0] code;
   logic                     last_chan;
   logic                     last_fold;
   logic [FOLD_BITS-1:0]     fold_nxt;

   assign fin_ready  = (state == IDLE);
   assign dout_valid = (state == STREAM);
   assign last_chan  = (chan == cur_cnt - 8'd1);
   assign last_fold  = (fold == FOLD_BITS'(NUM_FOLDS - 1));
   assign fold_nxt   = fold + 1'b1;
   assign feat_idx   = IDX_W'(cur_base + int'(chan));
   assign code       = feat_mem[feat_idx];

   // Look up the current modality's count and base, and the next non-empty modality after it.
   always_comb begin
      cur_cnt   = 8'd0;
      cur_base  = 0;
      nxt_found = 1'b0;
      nxt_mod   = 4'd0;
      for (int m = 0; m < NUM_MODALITIES; m++) begin
         if (4'(m) == modality) begin
            cur_cnt  = cnt_of(m);
            cur_base = base_of(m);
         end
      end
      for (int m = NUM_MODALITIES - 1; m >= 0; m--) begin
         if (4'(m) > modality && cnt_of(m) != 8'd0) begin
            nxt_found = 1'b1;
            nxt_mod   = 4'(m);
         end
      end
   end

   // Beat payload and sideband; everything is zero outside STREAM.
   always_comb begin
      projm_out      = '0;
      im_out         = im;
      dout_fold      = fold;
      dout_modality  = modality;
      dout_last_chan = 1'b0;
      dout_last      = 1'b0;
      if (state == STREAM) begin
         if (code == CHANNEL_WIDTH'(1))
            projm_out = SEED_HV[int'(fold)*FOLD_WIDTH +: FOLD_WIDTH];
         else if (code == CHANNEL_WIDTH'(2))
            projm_out = PROJM_NEG[int'(fold)*FOLD_WIDTH +: FOLD_WIDTH];
         dout_last_chan = last_chan;
         dout_last      = last_chan && !nxt_found && last_fold;
      end
   end

   // Feature snapshot taken on acceptance; deliberately not reset.
   always_ff @(posedge clk) begin
      if (fin_ready && fin_valid) begin
         for (int i = 0; i < TOTAL_NUM_CHANNEL; i++) feat_mem[i] <= features[i];
      end
   end

   // Sequencer: walk channel, then modality (skipping empty ones), then fold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         fold     <= '0;
         modality <= 4'd0;
         chan     <= 8'd0;
         im       <= '0;
      end else if (state == IDLE) begin
         if (fin_valid) begin
            state    <= STREAM;
            fold     <= '0;
            modality <= FIRST_MOD;
            chan     <= 8'd0;
            im       <= r90(PROJM_NEG[0 +: FOLD_WIDTH]);
         end
      end else if (dout_ready) begin
         if (!last_chan) begin
            chan <= chan + 8'd1;
            im   <= r90(im);
         end else if (nxt_found) begin
            modality <= nxt_mod;
            chan     <= 8'd0;
            im       <= r90(PROJM_NEG[int'(fold)*FOLD_WIDTH +: FOLD_WIDTH]);
         end else if (!last_fold) begin
            fold     <= fold_nxt;
            modality <= FIRST_MOD;
            chan     <= 8'd0;
            im       <= r90(PROJM_NEG[int'(fold_nxt)*FOLD_WIDTH +: FOLD_WIDTH]);
         end else begin
            state    <= IDLE;
            fold     <= '0;
            modality <= 4'd0;
            chan     <= 8'd0;
            im       <= '0;
         end
      end
   end

endmodule

// File: tb/tb_folded_hv_generator.sv
// Purpose: checks folded_hv_generator in three configurations against a nested-loop beat model.
// Latency: expects the first beat one cycle after acceptance and one idle cycle between samples.
// Backpressure: random dout_ready stalls; each presented beat must equal the pending model beat.
module tb_folded_hv_generator;

   typedef logic [1999:0] hv_t;
   typedef struct {
      logic [199:0] im;
      logic [199:0] pm;
      int           fold;
      int           modality;
      bit           lc;
      bit           last;
   } beat_t;

   localparam logic [1999:0] SEED_C = {100{20'h5A3C9}};

   logic clk;
   logic rst_n;
   logic fin_valid;
   logic dout_ready;
   int   sel;
   logic [1:0] feat [214];

   int n_checks;
   int n_fail;

   // Instance A: small config {1,2,1}
   logic       fin_valid_a, fin_ready_a, dout_valid_a, last_chan_a, last_a;
   logic [7:0] im_a, pm_a;
   logic [0:0] fold_a;
   logic [3:0] mod_a;
   logic [1:0] features_a [4];
   // Instance B: zero-count modality {1,0,2}
   logic       fin_valid_b, fin_ready_b, dout_valid_b, last_chan_b, last_b;
   logic [7:0] im_b, pm_b;
   logic [0:0] fold_b;
   logic [3:0] mod_b;
   logic [1:0] features_b [3];
   // Instance C: default dimensions
   logic         fin_valid_c, fin_ready_c, dout_valid_c, last_chan_c, last_c;
   logic [199:0] im_c, pm_c;
   logic [3:0]   fold_c;
   logic [3:0]   mod_c;
   logic [1:0]   features_c [214];

   logic         obs_vld, obs_fin_ready, obs_lc, obs_last;
   logic [199:0] obs_im, obs_pm;
   logic [3:0]   obs_fold, obs_mod;
   logic [409:0] obs_pack;

   assign fin_valid_a = fin_valid && (sel == 0);
   assign fin_valid_b = fin_valid && (sel == 1);
   assign fin_valid_c = fin_valid && (sel == 2);

   folded_hv_generator #(
      .HV_DIMENSION(16), .FOLD_WIDTH(8), .NUM_FOLDS(2), .NUM_MODALITIES(3),
      .CHANNEL_COUNTS({8'd1, 8'd2, 8'd1}), .TOTAL_NUM_CHANNEL(4), .CHANNEL_WIDTH(2),
      .SEED_HV(16'hA5C3)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .fin_valid(fin_valid_a), .fin_ready(fin_ready_a),
      .features(features_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready),
      .im_out(im_a), .projm_out(pm_a), .dout_fold(fold_a), .dout_modality(mod_a),
      .dout_last_chan(last_chan_a), .dout_last(last_a)
   );

   folded_hv_generator #(
      .HV_DIMENSION(16), .FOLD_WIDTH(8), .NUM_FOLDS(2), .NUM_MODALITIES(3),
      .CHANNEL_COUNTS({8'd2, 8'd0, 8'd1}), .TOTAL_NUM_CHANNEL(3), .CHANNEL_WIDTH(2),
      .SEED_HV(16'hA5C3)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .fin_valid(fin_valid_b), .fin_ready(fin_ready_b),
      .features(features_b), .dout_valid(dout_valid_b), .dout_ready(dout_ready),
      .im_out(im_b), .projm_out(pm_b), .dout_fold(fold_b), .dout_modality(mod_b),
      .dout_last_chan(last_chan_b), .dout_last(last_b)
   );

   folded_hv_generator #(
      .SEED_HV(SEED_C)
   ) u_dut_c (
      .clk(clk), .rst_n(rst_n), .fin_valid(fin_valid_c), .fin_ready(fin_ready_c),
      .features(features_c), .dout_valid(dout_valid_c), .dout_ready(dout_ready),
      .im_out(im_c), .projm_out(pm_c), .dout_fold(fold_c), .dout_modality(mod_c),
      .dout_last_chan(last_chan_c), .dout_last(last_c)
   );

   // Fan the shared feature array out to each instance.
   always_comb begin
      for (int i = 0; i < 4; i++)   features_a[i] = feat[i];
      for (int i = 0; i < 3; i++)   features_b[i] = feat[i];
      for (int i = 0; i < 214; i++) features_c[i] = feat[i];
   end

   // Select the instance under test onto common observation signals.
   always_comb begin
      obs_vld = 1'b0; obs_fin_ready = 1'b0; obs_lc = 1'b0; obs_last = 1'b0;
      obs_im = '0; obs_pm = '0; obs_fold = '0; obs_mod = '0;
      case (sel)
         0: begin
            obs_vld = dout_valid_a; obs_fin_ready = fin_ready_a; obs_lc = last_chan_a; obs_last = last_a;
            obs_im = 200'(im_a); obs_pm = 200'(pm_a); obs_fold = 4'(fold_a); obs_mod = mod_a;
         end
         1: begin
            obs_vld = dout_valid_b; obs_fin_ready = fin_ready_b; obs_lc = last_chan_b; obs_last = last_b;
            obs_im = 200'(im_b); obs_pm = 200'(pm_b); obs_fold = 4'(fold_b); obs_mod = mod_b;
         end
         default: begin
            obs_vld = dout_valid_c; obs_fin_ready = fin_ready_c; obs_lc = last_chan_c; obs_last = last_c;
            obs_im = im_c; obs_pm = pm_c; obs_fold = fold_c; obs_mod = mod_c;
         end
      endcase
   end

   assign obs_pack = {obs_im, obs_pm, obs_fold, obs_mod, obs_lc, obs_last};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model configuration for the selected instance.
   int  cfg_hv, cfg_fw, cfg_nf, cfg_nmod;
   int  cfg_cnt [3];
   hv_t cfg_seed;
   beat_t exp_q [$];

   task automatic check_eq(input string tag, input logic [409:0] got, input logic [409:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic hv_t mask_of(input int n);
      hv_t ones;
      ones = '1;
      return ones >> (2000 - n);
   endfunction

   function automatic hv_t rw(input hv_t x, input int n);
      return ((x << 1) ^ (x >> 1)) & mask_of(n);
   endfunction

   function automatic logic [409:0] pack(input beat_t b);
      return {b.im, b.pm, 4'(b.fold), 4'(b.modality), b.lc, b.last};
   endfunction

   task automatic set_cfg(input int s);
      sel = s;
      if (s == 2) begin
         cfg_hv = 2000; cfg_fw = 200; cfg_nf = 10; cfg_nmod = 3;
         cfg_cnt[0] = 32; cfg_cnt[1] = 77; cfg_cnt[2] = 105;
         cfg_seed = SEED_C;
      end else begin
         cfg_hv = 16; cfg_fw = 8; cfg_nf = 2; cfg_nmod = 3;
         cfg_seed = 2000'(16'hA5C3);
         if (s == 0) begin cfg_cnt[0] = 1; cfg_cnt[1] = 2; cfg_cnt[2] = 1; end
         else        begin cfg_cnt[0] = 1; cfg_cnt[1] = 0; cfg_cnt[2] = 2; end
      end
   endtask

   // Enumerate every beat of one sample: folds outermost, then modalities, then channels.
   task automatic build_model();
      hv_t neg, nslice, pslice, im, pm;
      int  total, k, base;
      beat_t b;
      exp_q.delete();
      total = 0;
      for (int m = 0; m < cfg_nmod; m++) total += cfg_cnt[m];
      neg = rw(cfg_seed, cfg_hv);
      k = 0;
      im = '0;
      for (int f = 0; f < cfg_nf; f++) begin
         nslice = (neg >> (f * cfg_fw)) & mask_of(cfg_fw);
         pslice = (cfg_seed >> (f * cfg_fw)) & mask_of(cfg_fw);
         base = 0;
         for (int m = 0; m < cfg_nmod; m++) begin
            for (int c = 0; c < cfg_cnt[m]; c++) begin
               im = (c == 0) ? rw(nslice, cfg_fw) : rw(im, cfg_fw);
               case (feat[base + c])
                  2'd1:    pm = pslice;
                  2'd2:    pm = nslice;
                  default: pm = '0;
               endcase
               b.im = im[199:0];
               b.pm = pm[199:0];
               b.fold = f;
               b.modality = m;
               b.lc = (c == cfg_cnt[m] - 1);
               b.last = (k == cfg_nf * total - 1);
               exp_q.push_back(b);
               k++;
            end
            base += cfg_cnt[m];
         end
      end
   endtask

   // Offer one sample and consume its beats. Called at a negedge; returns at negedge+1
   // after the sample, or at a negedge when stop_at beats have fired.
   task automatic run_sample(input bit bp, input bit hold, input int stop_at);
      int idx, cyc, n, budget;
      build_model();
      n = exp_q.size();
      budget = 4 * n + 50;
      fin_valid = 1'b1;
      #1;
      check_eq("fin_ready_idle", 410'(obs_fin_ready), 410'(1));
      check_eq("idle_no_vld", 410'(obs_vld), 410'(0));
      @(posedge clk);
      @(negedge clk);
      if (!hold) fin_valid = 1'b0;
      else for (int i = 0; i < 214; i++) feat[i] = 2'($urandom_range(0, 3));
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < budget) begin
         if (stop_at >= 0 && idx == stop_at) return;
         dout_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         check_eq("dout_vld", 410'(obs_vld), 410'(1));
         check_eq("vld_rdy_excl", 410'(obs_vld & obs_fin_ready), 410'(0));
         check_eq($sformatf("beat%0d", idx), obs_pack, pack(exp_q[idx]));
         if (dout_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      if (idx < n) check_eq("beat_timeout", 410'(idx), 410'(n));
      dout_ready = 1'b1;
      #1;
      check_eq("done_vld", 410'(obs_vld), 410'(0));
      check_eq("done_fin_ready", 410'(obs_fin_ready), 410'(1));
   endtask

   task automatic set_base_feat();
      for (int i = 0; i < 214; i++) feat[i] = 2'd0;
      feat[0] = 2'd1; feat[1] = 2'd2; feat[2] = 2'd0; feat[3] = 2'd3;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst_n = 1'b0;
      fin_valid = 1'b0;
      dout_ready = 1'b1;
      sel = 0;
      for (int i = 0; i < 214; i++) feat[i] = 2'd0;
      repeat (3) @(negedge clk);

      // Reset state of every instance.
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check_eq($sformatf("rst_vld%0d", s), 410'(obs_vld), 410'(0));
         check_eq($sformatf("rst_fin_ready%0d", s), 410'(obs_fin_ready), 410'(1));
         check_eq($sformatf("rst_outputs%0d", s), obs_pack, 410'(0));
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Baseline stream, then the same sample under random stalls.
      set_cfg(0);
      set_base_feat();
      run_sample(1'b0, 1'b0, -1);
      @(negedge clk);
      run_sample(1'b1, 1'b0, -1);
      @(negedge clk);

      // Zero-count modality is skipped.
      set_cfg(1);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) feat[i] = 2'($urandom_range(0, 3));
         run_sample(1'b1, 1'b0, -1);
         @(negedge clk);
      end

      // Reset while beat 3 is presented, then a clean rerun.
      set_cfg(0);
      set_base_feat();
      run_sample(1'b0, 1'b0, 2);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_vld", 410'(obs_vld), 410'(0));
      check_eq("midrst_fin_ready", 410'(obs_fin_ready), 410'(1));
      check_eq("midrst_outputs", obs_pack, 410'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_eq("postrst_vld", 410'(obs_vld), 410'(0));
      check_eq("postrst_fin_ready", 410'(obs_fin_ready), 410'(1));
      @(negedge clk);
      run_sample(1'b0, 1'b0, -1);
      @(negedge clk);

      // Back-to-back samples with fin_valid held and features changing mid-stream.
      for (int i = 0; i < 4; i++) feat[i] = 2'($urandom_range(0, 3));
      run_sample(1'b0, 1'b1, -1);
      run_sample(1'b1, 1'b1, -1);
      run_sample(1'b0, 1'b0, -1);
      @(negedge clk);

      // Default dimensions: all-one features, then random features with stalls.
      set_cfg(2);
      for (int i = 0; i < 214; i++) feat[i] = 2'd1;
      run_sample(1'b0, 1'b0, -1);
      @(negedge clk);
      for (int i = 0; i < 214; i++) feat[i] = 2'($urandom_range(0, 3));
      run_sample(1'b1, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
